// File: rtl/irom_fetch_pkg.sv
// Shared types and defaults for the instruction-ROM fetch unit.
// Fetch FSM state encodings and default widths.
package irom_fetch_pkg;

    localparam int WORD_W        = 32;
    localparam int AW_DEF        = 8;
    localparam int FIFO_LOG2_DEF = 2;
    localparam int TIMEOUT_DEF   = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/irom_fetch_fifo.sv
// Prefetch FIFO for irom_fetch: register array, synchronous flush, occupancy count.
// The head is read straight out of the register array, so outputs come from flops.
module irom_fetch_fifo #(
    parameter int W    = 40,
    parameter int LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic [W-1:0]    push_data,
    input  logic            pop,
    output logic [W-1:0]    head_data,
    output logic            head_valid,
    output logic [LOG2:0]   count
);

    localparam int            DEPTH = 2 ** LOG2;
    localparam logic [LOG2:0] FULL  = (LOG2 + 1)'(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [LOG2-1:0] wptr, rptr;
    logic            do_push, do_pop;

    assign do_pop     = pop && (count != '0);
    // A pop in the same cycle frees the slot, so a push at full is still legal.
    assign do_push    = push && ((count != FULL) || do_pop);
    assign head_valid = (count != '0);
    assign head_data  = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + {{LOG2{1'b0}}, do_push} - {{LOG2{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/irom_fetch.sv
// Wishbone read initiator streaming ROM words into a prefetch FIFO with redirect support.
// Optional bus timeout when IROM_FETCH_TIMEOUT_EN is defined; otherwise err is tied low.
module irom_fetch
    import irom_fetch_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int FIFO_LOG2 = FIFO_LOG2_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [AW-1:0]     wb_addr,
    input  logic [WORD_W-1:0] wb_rdata,
    output logic              wb_cyc,
    input  logic              wb_ack,
    input  logic              jmp_valid,
    input  logic [AW-1:0]     jmp_addr,
    output logic              ins_valid,
    output logic [WORD_W-1:0] ins_data,
    output logic [AW-1:0]     ins_pc,
    input  logic              ins_ready,
    output logic              err
);

    localparam logic [FIFO_LOG2:0] DEPTH = (FIFO_LOG2 + 1)'(2 ** FIFO_LOG2);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("irom_fetch: TIMEOUT must be at least 1");
    end

    fetch_state_e              state;
    logic [AW-1:0]             pc;
    logic [FIFO_LOG2:0]        fifo_count;
    logic [WORD_W+AW-1:0]      head;
    logic                      push, pop, has_credit, tmo_hit;

    // A redirect flushes the FIFO, so neither the acked word nor a pop survives it.
    assign push       = (state == ST_REQ) && wb_ack && !jmp_valid;
    assign pop        = ins_valid && ins_ready && !jmp_valid;
    assign has_credit = (fifo_count < DEPTH);
    assign ins_data   = head[WORD_W+AW-1:AW];
    assign ins_pc     = head[AW-1:0];

    irom_fetch_fifo #(
        .W    (WORD_W + AW),
        .LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (jmp_valid),
        .push       (push),
        .push_data  ({wb_rdata, wb_addr}),
        .pop        (pop),
        .head_data  (head),
        .head_valid (ins_valid),
        .count      (fifo_count)
    );

`ifdef IROM_FETCH_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = wb_cyc && !wb_ack && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (!wb_cyc || wb_ack || tmo_hit) tmo_cnt <= '0;
            else                              tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wb_cyc  <= 1'b0;
            wb_addr <= '0;
            pc      <= '0;
        end else begin
            if (jmp_valid) pc <= jmp_addr;
            case (state)
                ST_IDLE: begin
                    if (!jmp_valid && has_credit) begin
                        state   <= ST_REQ;
                        wb_cyc  <= 1'b1;
                        wb_addr <= pc;
                    end
                end
                ST_REQ: begin
                    if (wb_ack) begin
                        state  <= ST_IDLE;
                        wb_cyc <= 1'b0;
                        if (!jmp_valid) pc <= pc + AW'(1);
                    end else if (tmo_hit) begin
                        // Abort; pc is untouched so the same address is retried.
                        state  <= ST_IDLE;
                        wb_cyc <= 1'b0;
                    end else if (jmp_valid) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wb_ack || tmo_hit) begin
                        state  <= ST_IDLE;
                        wb_cyc <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    wb_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irom_fetch.sv
// Scoreboard bench for irom_fetch: ROM model mem[i]=0xA5000000+i, directed fetch/jump/wrap vectors.
// Exercises the bus-timeout path as well when IROM_FETCH_TIMEOUT_EN is defined.
module tb_irom_fetch;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  wb_addr;
    logic [31:0] wb_rdata;
    logic        wb_cyc;
    logic        wb_ack;
    logic        jmp_valid = 1'b0;
    logic [7:0]  jmp_addr = 8'h00;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [7:0]  ins_pc;
    logic        ins_ready = 1'b0;
    logic        err;
    logic        ack_en = 1'b1;

    int          checks = 0;
    int          failures = 0;
    int          n_pops = 0;
    logic [7:0]  exp_pc = 8'h00;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    // Single-cycle-latency ROM responder.
    assign wb_ack   = wb_cyc & ack_en;
    assign wb_rdata = 32'hA500_0000 | {24'h0, wb_addr};

    irom_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_addr   (wb_addr),
        .wb_rdata  (wb_rdata),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack),
        .jmp_valid (jmp_valid),
        .jmp_addr  (jmp_addr),
        .ins_valid (ins_valid),
        .ins_data  (ins_data),
        .ins_pc    (ins_pc),
        .ins_ready (ins_ready),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ins_valid && ins_ready && !jmp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got pc=%0h data=%0h expected no output", ins_pc, ins_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("pop_data", ins_data, e.d);
                    chk("pop_pc", {24'h0, ins_pc}, {24'h0, e.pc});
                end
                n_pops++;
            end
        end
    endtask

    // Queue n sequential expectations, consume them, stop right after the last pop.
    task automatic run(input int n, input bit rate);
        int target;
        int t;
        int acks;
        exp_t e;
        target = n_pops + n;
        t = 0;
        acks = 0;
        for (int i = 0; i < n; i++) begin
            e.d  = 32'hA500_0000 + {24'h0, exp_pc};
            e.pc = exp_pc;
            sb_q.push_back(e);
            exp_pc = exp_pc + 8'd1;
        end
        ins_ready = 1'b1;
        while (n_pops < target && t < 400) begin
            tick();
            t++;
            if (rate && t > 12 && t <= 32 && wb_ack) acks++;
        end
        ins_ready = 1'b0;
        chk("run_all_popped", n_pops, target);
        chk("run_queue_empty", sb_q.size(), 0);
        if (rate) chk("acks_per_20clk", acks, 10);
    endtask

    task automatic do_jump(input logic [7:0] a);
        jmp_valid = 1'b1;
        jmp_addr  = a;
        tick();
        jmp_valid = 1'b0;
        exp_pc    = a;
    endtask

    task automatic wait_req(input logic [7:0] a, input string name);
        int t;
        t = 0;
        while (!(wb_cyc && wb_addr == a) && t < 50) begin
            tick();
            t++;
        end
        chk(name, {31'h0, wb_cyc && wb_addr == a}, 32'h1);
    endtask

    initial begin
        int acks;
        fork
            monitor();
        join_none
        fork
            begin
                #500000;
                $display("FAIL watchdog: got no finish expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        repeat (3) tick();
        chk("rst_cyc", {31'h0, wb_cyc}, 32'h0);
        chk("rst_addr", {24'h0, wb_addr}, 32'h0);
        chk("rst_valid", {31'h0, ins_valid}, 32'h0);
        chk("rst_data", ins_data, 32'h0);
        chk("rst_pc", {24'h0, ins_pc}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);

        // Consumer stalled: exactly depth words fetched, then the bus goes quiet
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wb_ack) acks++;
        end
        chk("stall_acks", acks, 4);
        chk("stall_cyc_idle", {31'h0, wb_cyc}, 32'h0);
        chk("stall_head_valid", {31'h0, ins_valid}, 32'h1);
        chk("stall_head_pc", {24'h0, ins_pc}, 32'h0);

        // Stream resumes in order past the prefetched words; then steady-state rate
        run(10, 1'b0);
        repeat (10) tick();
        run(30, 1'b1);
        repeat (10) tick();

        // Redirect while REQ for 0x05 with no ack: data dropped, DRAIN holds the bus
        do_jump(8'h01);
        exp_pc = 8'h01;
        sb_q.push_back('{32'hA500_0001, 8'h01});
        sb_q.push_back('{32'hA500_0002, 8'h02});
        sb_q.push_back('{32'hA500_0003, 8'h03});
        sb_q.push_back('{32'hA500_0004, 8'h04});
        ins_ready = 1'b1;
        wait_req(8'h05, "reach_req_05");
        ack_en    = 1'b0;
        ins_ready = 1'b0;
        chk("pre_jump_pops", sb_q.size(), 0);
        do_jump(8'h80);
        chk("jump_flush", {31'h0, ins_valid}, 32'h0);
        chk("drain_cyc", {31'h0, wb_cyc}, 32'h1);
        chk("drain_addr", {24'h0, wb_addr}, 32'h05);
        tick();
        chk("drain_hold", {31'h0, wb_cyc}, 32'h1);
        ack_en = 1'b1;
        tick();
        chk("drain_done", {31'h0, wb_cyc}, 32'h0);
        run(3, 1'b0);

        // Redirect coincident with ack: word dropped, no DRAIN, next fetch at target
        do_jump(8'h10);
        wait_req(8'h10, "reach_req_10");
        jmp_valid = 1'b1;
        jmp_addr  = 8'h40;
        tick();
        jmp_valid = 1'b0;
        chk("coinc_no_drain", {31'h0, wb_cyc}, 32'h0);
        chk("coinc_flush", {31'h0, ins_valid}, 32'h0);
        tick();
        chk("coinc_next_cyc", {31'h0, wb_cyc}, 32'h1);
        chk("coinc_next_addr", {24'h0, wb_addr}, 32'h40);
        exp_pc = 8'h40;
        run(3, 1'b0);

        // PC wrap at 0xFF
        do_jump(8'hFE);
        run(4, 1'b0);

`ifdef IROM_FETCH_TIMEOUT_EN
        begin
            int hi;
            ack_en = 1'b0;
            do_jump(8'h20);
            wait_req(8'h20, "tmo_first_req");
            hi = 0;
            while (wb_cyc && hi < 40) begin
                hi++;
                tick();
            end
            chk("tmo_cyc_cycles", hi, 15);
            chk("tmo_err", {31'h0, err}, 32'h1);
            tick();
            chk("tmo_retry_cyc", {31'h0, wb_cyc}, 32'h1);
            chk("tmo_retry_addr", {24'h0, wb_addr}, 32'h20);
            ack_en = 1'b1;
            exp_pc = 8'h20;
            run(2, 1'b0);
            chk("tmo_err_sticky", {31'h0, err}, 32'h1);
        end
`else
        chk("err_tied_low", {31'h0, err}, 32'h0);
`endif

        // Reset asserted mid-cycle while the bus is busy
        wait_req(exp_pc, "reach_req_mid_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", {31'h0, wb_cyc}, 32'h0);
        chk("async_rst_valid", {31'h0, ins_valid}, 32'h0);
        chk("async_rst_err", {31'h0, err}, 32'h0);
        tick();
        rst_n = 1'b1;
        exp_pc = 8'h00;
        run(2, 1'b0);

        chk("final_queue_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
